// File: rtl/seg7_pattern_reader.sv
// seg7_pattern_reader
// Samples an active-low seven-segment bus and synchronises it. It filters out
// glitches, decodes the glyphs 0..4 and blank, and emits one event for each
// newly stabilised pattern on a valid/ready handshake.
// Build option: define SEG7_READER_FIFO_EN to replace the single event
// register with a FIFO_DEPTH-entry FIFO.
//
// state  | meaning
// -------+-------------------------------------------------------------
// SETTLE | q is changing or still being qualified; cnt counts stable cycles
// LOCKED | current q has been judged; wait for the next change of q
module seg7_pattern_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [2:0] ev_digit,
    output logic       ev_blank,
    output logic       ev_err,
    output logic       overflow
);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [0:0] SETTLE    = 1'b0;
    localparam logic [0:0] LOCKED    = 1'b1;
    localparam logic [7:0] CNT_TC    = 8'(STABLE_CYCLES);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("seg7_pattern_reader: illegal STABLE_CYCLES or FIFO_DEPTH");
    end

    logic [6:0] sync_1;
    logic [6:0] q;
    logic [6:0] q_prev;
    logic [6:0] last_acc;
    logic [7:0] cnt;
    logic [0:0] state;
    logic       q_changed;
    logic       gen_ev;
    logic       ev_pop;
    logic [4:0] gen_rec;   // {blank, err, digit}

    assign q_changed = (q != q_prev);
    assign ev_pop    = ev_valid && ev_ready;
    assign gen_ev    = (state == SETTLE) && !q_changed && (cnt == CNT_TC) && (q != last_acc);

    // Two-flop synchroniser plus one cycle of history for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= SEG_BLANK;
            q      <= SEG_BLANK;
            q_prev <= SEG_BLANK;
        end else begin
            sync_1 <= seg_n;
            q      <= sync_1;
            q_prev <= q;
        end
    end

    // Stability filter: cnt saturates at the terminal count and is never wrapped
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SETTLE;
            cnt      <= 8'd0;
            last_acc <= SEG_BLANK;
        end else if (q_changed) begin
            state <= SETTLE;
            cnt   <= 8'd1;
        end else if (state == SETTLE) begin
            if (cnt == CNT_TC) begin
                state <= LOCKED;
                if (q != last_acc) begin
                    last_acc <= q;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Glyph decode of the pattern being accepted
    always_comb begin
        gen_rec = 5'b01000;
        case (q)
            7'h40:   gen_rec = 5'b00000;
            7'h79:   gen_rec = 5'b00001;
            7'h24:   gen_rec = 5'b00010;
            7'h30:   gen_rec = 5'b00011;
            7'h19:   gen_rec = 5'b00100;
            7'h7F:   gen_rec = 5'b10000;
            default: gen_rec = 5'b01000;
        endcase
    end

`ifdef SEG7_READER_FIFO_EN
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;

    // Pop is taken first, so a push into a full FIFO with a pop is accepted
    assign push     = gen_ev && ((count != DEPTH_L) || ev_pop);
    assign ev_valid = (count != '0);
    assign {ev_blank, ev_err, ev_digit} = ev_valid ? mem[rd_ptr] : 5'b00000;

    // Event storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= gen_rec;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ev_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !ev_pop) begin
                count <= count + 1'b1;
            end else if (!push && ev_pop) begin
                count <= count - 1'b1;
            end
            if (gen_ev && !push) begin
                overflow <= 1'b1;
            end
        end
    end
`else
    logic       ev_full;
    logic [4:0] ev_rec;

    assign ev_valid = ev_full;
    assign {ev_blank, ev_err, ev_digit} = ev_rec;

    // Single event register: load when empty or draining this cycle, else drop
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_full  <= 1'b0;
            ev_rec   <= 5'b00000;
            overflow <= 1'b0;
        end else if (gen_ev) begin
            if (!ev_full || ev_pop) begin
                ev_full <= 1'b1;
                ev_rec  <= gen_rec;
            end else begin
                overflow <= 1'b1;
            end
        end else if (ev_pop) begin
            ev_full <= 1'b0;
            ev_rec  <= 5'b00000;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Self-checking bench for seg7_pattern_reader. Patterns are driven as
// (value, hold length) pairs; the reference model decides per hold whether an
// event is due and queues the expected event record for the consumer side.
module tb_seg7_pattern_reader;
    localparam int STABLE = 4;
    localparam int DEPTH  = 4;
`ifdef SEG7_READER_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_digit;
    logic       ev_blank;
    logic       ev_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q [$];
    logic [6:0] m_last = 7'h7F;
    logic       m_ovf  = 1'b0;
    int         mode   = 0;     // 0: ready high, 1: stalled, 2: random ready
    int         stall_run = 0;

    logic [6:0] glyphs [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h7F};
    logic [6:0] fill   [6] = '{7'h40, 7'h24, 7'h79, 7'h30, 7'h7F, 7'h19};
    logic [6:0] ovl    [5] = '{7'h30, 7'h40, 7'h24, 7'h79, 7'h19};

    always #5 clk = ~clk;

    seg7_pattern_reader #(
        .STABLE_CYCLES(STABLE),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .seg_n   (seg_n),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_digit(ev_digit),
        .ev_blank(ev_blank),
        .ev_err  (ev_err),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected record {blank, err, digit} straight from the glyph table
    function automatic logic [4:0] glyph_ev(input logic [6:0] p);
        case (p)
            7'h40:   return 5'b00000;
            7'h79:   return 5'b00001;
            7'h24:   return 5'b00010;
            7'h30:   return 5'b00011;
            7'h19:   return 5'b00100;
            7'h7F:   return 5'b10000;
            default: return 5'b01000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a pattern for len cycles; in stalled mode ready pulses only at rdy_at
    task automatic drive_hold(input logic [6:0] pat, input int len, input int rdy_at);
        seg_n = pat;
        if (len > STABLE && pat != m_last) begin
            m_last = pat;
            if (mode == 1 && rdy_at < 0 && exp_q.size() >= CAP)
                m_ovf = 1'b1;
            else
                exp_q.push_back(glyph_ev(pat));
        end
        for (int i = 0; i < len; i++) begin
            if (mode == 0) begin
                ev_ready = 1'b1;
            end else if (mode == 1) begin
                ev_ready = (i == rdy_at);
            end else begin
                if (stall_run < 2 && $urandom_range(0, 3) == 0) begin
                    ev_ready = 1'b0;
                    stall_run++;
                end else begin
                    ev_ready = 1'b1;
                    stall_run = 0;
                end
            end
            tick();
        end
    endtask

    task automatic drain(input int n);
        mode = 0;
        ev_ready = 1'b1;
        repeat (n) tick();
    endtask

    // Consumer side: every handshake is compared against the model queue
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            chk("ev_fields_excl",
                ((ev_blank && ev_err) || ((ev_blank || ev_err) && ev_digit != 3'd0) ||
                 ev_digit > 3'd4) ? 1 : 0, 0);
            chk("ev_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0)
                chk("ev_record", {ev_blank, ev_err, ev_digit}, exp_q.pop_front());
        end
    end

    initial begin
        logic [6:0] p;
        logic [6:0] cur;
        int         len;
        int         r;

        reset    = 1'b1;
        seg_n    = 7'h7F;
        ev_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", ev_valid, 0);
        chk("rst_digit", ev_digit, 0);
        chk("rst_blank", ev_blank, 0);
        chk("rst_err",   ev_err,   0);
        chk("rst_ovf",   overflow, 0);
        reset = 1'b0;

        // Latency: pattern first sampled at edge k, valid after edge k+2+STABLE
        mode     = 0;
        ev_ready = 1'b1;
        seg_n    = 7'h24;
        exp_q.push_back(glyph_ev(7'h24));
        m_last   = 7'h24;
        repeat (STABLE + 2) tick();
        chk("lat_early_valid", ev_valid, 0);
        tick();
        chk("lat_valid", ev_valid, 1);
        chk("lat_digit", ev_digit, 2);
        repeat (10 - STABLE - 3) tick();

        // Short 1 is filtered, then 0, blank, error, 4
        drive_hold(7'h79, 3, -1);
        drive_hold(7'h40, 12, -1);
        drive_hold(7'h7F, 12, -1);
        drive_hold(7'h00, 12, -1);
        drive_hold(7'h19, 12, -1);
        chk("seq_drained", exp_q.size(), 0);

        // Fill the output, then the next event lands in the cycle it is popped
        mode = 1;
        for (int i = 0; i < CAP; i++) drive_hold(fill[i], 12, -1);
        drive_hold(fill[CAP], 12, STABLE + 2);
        chk("popload_valid", ev_valid, 1);
        chk("popload_head", {ev_blank, ev_err, ev_digit}, exp_q[0]);
        chk("popload_ovf", overflow, m_ovf);
        drain(CAP + 8);

        // Stalled consumer: one more event than the output can hold
        mode = 1;
        for (int i = 0; i <= CAP; i++) begin
            drive_hold(ovl[i], 12, -1);
            chk("ovf_step", overflow, m_ovf);
        end
        chk("ovf_head", ev_digit, 3);
        chk("ovf_head_valid", ev_valid, 1);
        drain(CAP + 8);

        // Reset with an event pending and a pattern half settled
        mode = 1;
        drive_hold(7'h79, 12, -1);
        seg_n = 7'h24;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rst2_valid", ev_valid, 0);
        chk("rst2_digit", ev_digit, 0);
        chk("rst2_blank", ev_blank, 0);
        chk("rst2_err",   ev_err,   0);
        chk("rst2_ovf",   overflow, 0);
        exp_q.delete();
        m_last   = 7'h7F;
        m_ovf    = 1'b0;
        reset    = 1'b0;
        mode     = 0;
        ev_ready = 1'b1;
        exp_q.push_back(glyph_ev(7'h24));
        m_last   = 7'h24;
        repeat (STABLE + 2) tick();
        chk("rst2_refilter_early", ev_valid, 0);
        tick();
        chk("rst2_refilter_valid", ev_valid, 1);
        chk("rst2_refilter_digit", ev_digit, 2);
        repeat (5) tick();

        // Random holds, short glitches and consumer stalls
        mode = 2;
        cur  = 7'h24;
        for (int h = 0; h < 80; h++) begin
            do begin
                r = $urandom_range(0, 9);
                p = (r < 6) ? glyphs[r] : 7'($urandom_range(0, 127));
            end while (p == cur);
            if ($urandom_range(0, 2) == 0)
                len = $urandom_range(1, STABLE - 1);
            else
                len = $urandom_range(STABLE + 2, STABLE + 8);
            if (h == 79) len = STABLE + 4;
            drive_hold(p, len, -1);
            cur = p;
        end
        drain(12);
        chk("rand_ovf", overflow, m_ovf);
        chk("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
